// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// mem_ctrl_pkg
// Shared state encoding, timeout default and request qualification helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int TIMEOUT_DEFAULT = 16;

  // One request type only, word-aligned address.
  function automatic logic req_is_legal(input logic rd, input logic wr,
                                        input logic [1:0] addr_lo);
    return (rd ^ wr) && (addr_lo == 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl
// MEM-stage load/store controller: stalls the pipeline around a single
// memory transaction, with timeout and illegal-request sticky errors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        err_clr,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err_timeout,
  output logic        err_illegal
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_to_q, err_to_d;
  logic        err_il_q, err_il_d;

  logic req_legal;
  logic req_illegal;

  assign req_legal   = req_is_legal(rd_req, wr_req, addr[1:0]);
  assign req_illegal = (rd_req && wr_req) || ((rd_req || wr_req) && (addr[1:0] != 2'b00));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    // Clear first, then let a same-cycle error event win.
    err_to_d = err_to_q && !err_clr;
    err_il_d = err_il_q && !err_clr;

    case (state_q)
      ST_IDLE: begin
        if (req_legal) begin
          state_d = ST_BUSY;
          cnt_d   = 8'd0;
          we_d    = wr_req;
          addr_d  = addr;
          wdata_d = wdata;
        end else if (req_illegal) begin
          err_il_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_to_d = 1'b1;
          rdata_d  = 32'd0;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_to_q <= 1'b0;
      err_il_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_to_q <= err_to_d;
      err_il_q <= err_il_d;
    end
  end

  assign mem_req     = (state_q == ST_BUSY);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = (state_q == ST_DONE) && !we_q;
  assign err_timeout = err_to_q;
  assign err_illegal = err_il_q;
  // Gated by rst_n so reset releases the pipeline even with a request pending.
  assign stall       = rst_n && (((state_q == ST_IDLE) && req_legal) || (state_q == ST_BUSY));

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// tb_mem_access_ctrl
// Scoreboard bench: expected load results queued at request time, popped
// on each rdata_valid strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        err_clr;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err_timeout;
  logic        err_illegal;

  int          checks;
  int          failures;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rd;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .addr        (addr),
    .wdata       (wdata),
    .err_clr     (err_clr),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .err_timeout (err_timeout),
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n && rdata_valid) begin
      if (exp_q.size() == 0) begin
        check("valid_unexpected", {31'd0, rdata_valid}, 32'd0);
      end else begin
        exp_rd = exp_q.pop_front();
        check("rdata", rdata, exp_rd);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that leaves DONE.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int ack_after,
                        input logic [31:0] rval, input logic exp_to);
    int n;
    int exp_len;
    rd_req = rd;
    wr_req = wr;
    addr   = a;
    wdata  = d;
    if (rd) exp_q.push_back(exp_to ? 32'd0 : rval);
    exp_len = (ack_after >= 0) ? ack_after + 1 : TIMEOUT;
    @(negedge clk);
    check("stall_request", {31'd0, stall}, 32'd1);
    check("mem_req_request", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    n = 0;
    while (mem_req && n < TIMEOUT + 4) begin
      if (n == ack_after) begin
        mem_ack   = 1'b1;
        mem_rdata = rval;
      end else begin
        mem_rdata = 32'hA5A5_0000 | 32'(n);
      end
      @(negedge clk);
      check("stall_busy", {31'd0, stall}, 32'd1);
      check("mem_we", {31'd0, mem_we}, {31'd0, wr});
      check("mem_addr", mem_addr, a);
      check("mem_wdata", mem_wdata, wr ? d : mem_wdata);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      n++;
    end
    check("busy_len", 32'(n), 32'(exp_len));
    check("stall_done", {31'd0, stall}, 32'd0);
    check("err_timeout_done", {31'd0, err_timeout}, {31'd0, exp_to});
    rd_req = 1'b0;
    wr_req = 1'b0;
    @(posedge clk); #1;
    check("mem_req_idle", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
    err_clr   = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;

    #12;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_errs", {30'd0, err_timeout, err_illegal}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 3, 32'h0, 1'b0);
    check("rdata_hold_after_write", rdata, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h0000_0030, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0044, 32'h0, -1, 32'h0, 1'b1);
    check("rdata_after_timeout", rdata, 32'd0);
    pulse_clr();
    check("err_timeout_cleared", {31'd0, err_timeout}, 32'd0);

    rd_req = 1'b1;
    addr   = 32'h0000_0003;
    @(negedge clk);
    check("stall_misaligned", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("err_illegal_misaligned", {31'd0, err_illegal}, 32'd1);
    check("mem_req_misaligned", {31'd0, mem_req}, 32'd0);
    wr_req  = 1'b1;
    addr    = 32'h0000_0050;
    err_clr = 1'b1;
    @(negedge clk);
    check("stall_both", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("err_illegal_set_wins", {31'd0, err_illegal}, 32'd1);
    check("mem_req_both", {31'd0, mem_req}, 32'd0);
    rd_req = 1'b0;
    wr_req = 1'b0;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("err_illegal_cleared", {31'd0, err_illegal}, 32'd0);

    rd_req = 1'b1;
    addr   = 32'h0000_0040;
    @(posedge clk); #1;
    check("mem_req_before_rst", {31'd0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mem_req_async_rst", {31'd0, mem_req}, 32'd0);
    check("stall_async_rst", {31'd0, stall}, 32'd0);
    check("rdata_async_rst", rdata, 32'd0);
    check("mem_addr_async_rst", mem_addr, 32'd0);
    rd_req = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    repeat (3) begin
      @(negedge clk);
      check("mem_req_late_ack", {31'd0, mem_req}, 32'd0);
      check("stall_late_ack", {31'd0, stall}, 32'd0);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("rdata_late_ack", rdata, 32'd0);

    access(1'b1, 1'b0, 32'h0000_0060, 32'h0, 1, 32'h0BAD_F00D, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
